atb_trace_buffer: RTL and testbench

ATB_TRACE_BUFFER -- requirements
Module: atb_trace_buffer

---
 rtl/atb_trace_pkg.sv | 40 ++++
 rtl/atb_trace_ram.sv | 45 ++++
 rtl/atb_trace_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_atb_trace_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/atb_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atb_trace_pkg
// Description : Shared types for the ATB trace buffer: capture FSM state
//               encoding and the stored entry layout {atlast, atid, atdata}.
// Revision    : 1.0 - initial release
// ============================================================================
package atb_trace_pkg;

    // Default ATB widths; the entry struct below is laid out for these.
    localparam int ATB_DATA_W = 64;
    localparam int ATB_ATID_W = 8;

    // Capture FSM state encoding (also exported on state_o).
    localparam logic [1:0] ST_IDLE_C    = 2'd0;
    localparam logic [1:0] ST_ARMED_C   = 2'd1;
    localparam logic [1:0] ST_POST_C    = 2'd2;
    localparam logic [1:0] ST_STOPPED_C = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_C,
        ST_ARMED   = ST_ARMED_C,
        ST_POST    = ST_POST_C,
        ST_STOPPED = ST_STOPPED_C
    } tb_state_e;

    // One stored beat; packed MSB-first as {atlast, atid, atdata}.
    typedef struct packed {
        logic                  atlast;
        logic [ATB_ATID_W-1:0] atid;
        logic [ATB_DATA_W-1:0] atdata;
    } atb_entry_t;

    // Width of one RAM entry for a given ATB configuration.
    function automatic int entry_width(input int data_w, input int atid_w);
        return 1 + atid_w + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/atb_trace_ram.sv
`default_nettype none
// ============================================================================
// Module      : atb_trace_ram
// Description : Simple dual-port trace storage, one write and one read port,
//               synchronous read with one cycle latency. Read data holds its
//               value when no read is requested. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module atb_trace_ram
    import atb_trace_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 73,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port: store the beat at the requested entry.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: registered read, holds last data when idle.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/atb_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : atb_trace_buffer
// Description : ATB trace capture buffer. Circular capture of ATB beats while
//               armed, trigger with programmable post-trigger beat count,
//               and a registered readout port usable once capture has ended.
//               Optional build macro ATB_TRACE_BUF_FILTER_EN adds an ATID
//               match/mask filter (flt_id_i / flt_mask_i).
// Revision    : 1.0 - initial release
// ============================================================================
module atb_trace_buffer
    import atb_trace_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 64,
    parameter int ATID_WIDTH = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             s_atvalid_i,
    input  logic [ATID_WIDTH-1:0]            s_atid_i,
    input  logic [DATA_WIDTH-1:0]            s_atdata_i,
    input  logic                             s_atlast_i,
    output logic                             s_atready_o,
    input  logic                             enable_i,
    input  logic                             trig_i,
    input  logic [AW-1:0]                    post_cnt_i,
`ifdef ATB_TRACE_BUF_FILTER_EN
    input  logic [ATID_WIDTH-1:0]            flt_id_i,
    input  logic [ATID_WIDTH-1:0]            flt_mask_i,
`endif
    input  logic                             rd_en_i,
    input  logic [AW-1:0]                    rd_addr_i,
    output logic                             rd_valid_o,
    output logic                             rd_err_o,
    output logic [ATID_WIDTH+DATA_WIDTH:0]   rd_data_o,
    output logic [1:0]                       state_o,
    output logic [AW-1:0]                    wr_ptr_o,
    output logic [AW-1:0]                    trig_ptr_o,
    output logic                             wrapped_o,
    output logic [15:0]                      drop_cnt_o
);

    localparam int          EW       = entry_width(DATA_WIDTH, ATID_WIDTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    tb_state_e     state_q,    state_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] trig_ptr_q, trig_ptr_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic          wrapped_q,  wrapped_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_err_q,   rd_err_d;
    logic          rd_zero_q,  rd_zero_d;

    logic          accept;
    logic          capture;
    logic          id_match;
    logic          store;
    logic          drop;
    logic          ram_re;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] ram_rdata;

    // Ready follows reset directly so beats are never accepted in reset.
    assign s_atready_o = rst_ni;
    assign accept      = s_atvalid_i && s_atready_o;
    assign capture     = (state_q == ST_ARMED) || (state_q == ST_POST);

    generate
`ifdef ATB_TRACE_BUF_FILTER_EN
        if (1) begin : g_filter
            assign id_match = ((s_atid_i ^ flt_id_i) & flt_mask_i) == '0;
        end
`else
        if (1) begin : g_no_filter
            assign id_match = 1'b1;
        end
`endif
    endgenerate

    assign store    = accept && capture && id_match;
    assign drop     = accept && !(capture && id_match);
    assign wr_entry = {s_atlast_i, s_atid_i, s_atdata_i};
    assign ram_re   = rd_en_i && !capture && rst_ni;

    // Next-state logic for the capture FSM, pointers, counters and readout.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        trig_ptr_d = trig_ptr_q;
        post_cnt_d = post_cnt_q;
        wrapped_d  = wrapped_q;
        drop_cnt_d = drop_cnt_q;

        if (store) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_ptr_q == LAST_IDX) begin
                wrapped_d = 1'b1;
            end
        end
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d    = ST_ARMED;
                    wr_ptr_d   = '0;
                    trig_ptr_d = '0;
                    wrapped_d  = 1'b0;
                    drop_cnt_d = '0;
                end
            end
            ST_ARMED: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (trig_i) begin
                    // The trigger-cycle beat is written but not counted.
                    state_d    = ST_POST;
                    trig_ptr_d = wr_ptr_q;
                    post_cnt_d = post_cnt_i;
                end
            end
            ST_POST: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (post_cnt_q == '0) begin
                    state_d = ST_STOPPED;
                end else if (store) begin
                    post_cnt_d = post_cnt_q - AW'(1);
                end
            end
            default: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Reads during capture return an error with zero data.
        rd_valid_d = rd_en_i;
        rd_err_d   = rd_en_i && capture;
        rd_zero_d  = rd_en_i ? capture : rd_zero_q;
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            trig_ptr_q <= '0;
            post_cnt_q <= '0;
            wrapped_q  <= 1'b0;
            drop_cnt_q <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            trig_ptr_q <= trig_ptr_d;
            post_cnt_q <= post_cnt_d;
            wrapped_q  <= wrapped_d;
            drop_cnt_q <= drop_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    atb_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (store),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .re_i    (ram_re),
        .raddr_i (rd_addr_i),
        .rdata_o (ram_rdata)
    );

    // RAM output holds between reads; the zero flag masks it after reset
    // and after an error response.
    assign rd_data_o  = rd_zero_q ? '0 : ram_rdata;
    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign state_o    = state_q;
    assign wr_ptr_o   = wr_ptr_q;
    assign trig_ptr_o = trig_ptr_q;
    assign wrapped_o  = wrapped_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_atb_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_atb_trace_buffer
// Description : Directed self-checking bench for atb_trace_buffer, DEPTH=16.
//               Filter scenario is enabled with ATB_TRACE_BUF_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 64;
    localparam int IW    = 8;
    localparam int EW    = 1 + IW + DW;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          s_atvalid_i;
    logic [IW-1:0] s_atid_i;
    logic [DW-1:0] s_atdata_i;
    logic          s_atlast_i;
    logic          s_atready_o;
    logic          enable_i;
    logic          trig_i;
    logic [AW-1:0] post_cnt_i;
`ifdef ATB_TRACE_BUF_FILTER_EN
    logic [IW-1:0] flt_id_i;
    logic [IW-1:0] flt_mask_i;
`endif
    logic          rd_en_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_valid_o;
    logic          rd_err_o;
    logic [EW-1:0] rd_data_o;
    logic [1:0]    state_o;
    logic [AW-1:0] wr_ptr_o;
    logic [AW-1:0] trig_ptr_o;
    logic          wrapped_o;
    logic [15:0]   drop_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    atb_trace_buffer #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .ATID_WIDTH (IW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .s_atvalid_i (s_atvalid_i),
        .s_atid_i    (s_atid_i),
        .s_atdata_i  (s_atdata_i),
        .s_atlast_i  (s_atlast_i),
        .s_atready_o (s_atready_o),
        .enable_i    (enable_i),
        .trig_i      (trig_i),
        .post_cnt_i  (post_cnt_i),
`ifdef ATB_TRACE_BUF_FILTER_EN
        .flt_id_i    (flt_id_i),
        .flt_mask_i  (flt_mask_i),
`endif
        .rd_en_i     (rd_en_i),
        .rd_addr_i   (rd_addr_i),
        .rd_valid_o  (rd_valid_o),
        .rd_err_o    (rd_err_o),
        .rd_data_o   (rd_data_o),
        .state_o     (state_o),
        .wr_ptr_o    (wr_ptr_o),
        .trig_ptr_o  (trig_ptr_o),
        .wrapped_o   (wrapped_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs,
                            input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input logic [IW-1:0] id, input logic [DW-1:0] d,
                        input logic last);
        s_atvalid_i = 1'b1;
        s_atid_i    = id;
        s_atdata_i  = d;
        s_atlast_i  = last;
        tick();
        s_atvalid_i = 1'b0;
        s_atlast_i  = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [AW-1:0] a,
                            input logic [EW-1:0] exp);
        rd_en_i   = 1'b1;
        rd_addr_i = a;
        tick();
        rd_en_i   = 1'b0;
        check_eq({tag, "_vld"}, 128'(rd_valid_o), 128'(1));
        check_eq({tag, "_err"}, 128'(rd_err_o), 128'(0));
        check_eq({tag, "_dat"}, 128'(rd_data_o), 128'(exp));
    endtask

    initial begin
        rst_ni      = 1'b0;
        s_atvalid_i = 1'b0;
        s_atid_i    = '0;
        s_atdata_i  = '0;
        s_atlast_i  = 1'b0;
        enable_i    = 1'b0;
        trig_i      = 1'b0;
        post_cnt_i  = '0;
        rd_en_i     = 1'b0;
        rd_addr_i   = '0;
`ifdef ATB_TRACE_BUF_FILTER_EN
        flt_id_i    = '0;
        flt_mask_i  = '0;
`endif
        tick();
        tick();
        check_eq("rst_state",   128'(state_o), 128'(0));
        check_eq("rst_ready",   128'(s_atready_o), 128'(0));
        check_eq("rst_wrptr",   128'(wr_ptr_o), 128'(0));
        check_eq("rst_trigptr", 128'(trig_ptr_o), 128'(0));
        check_eq("rst_wrapped", 128'(wrapped_o), 128'(0));
        check_eq("rst_drop",    128'(drop_cnt_o), 128'(0));
        check_eq("rst_rdvld",   128'(rd_valid_o), 128'(0));
        check_eq("rst_rderr",   128'(rd_err_o), 128'(0));
        check_eq("rst_rddata",  128'(rd_data_o), 128'(0));
        rst_ni = 1'b1;
        #1;
        check_eq("ready_run", 128'(s_atready_o), 128'(1));

        // Trigger in IDLE is ignored; a beat in IDLE is dropped.
        trig_i = 1'b1;
        beat(8'h01, 64'hDEAD, 1'b0);
        trig_i = 1'b0;
        check_eq("idle_trig_state", 128'(state_o), 128'(0));
        check_eq("idle_drop",       128'(drop_cnt_o), 128'(1));

        // Simple capture of 5 beats then readout.
        enable_i = 1'b1;
        tick();
        check_eq("arm_state", 128'(state_o), 128'(1));
        check_eq("arm_drop",  128'(drop_cnt_o), 128'(0));
        for (int i = 0; i < 5; i++) begin
            beat(8'h01, 64'h10 + 64'(i), (i == 4));
        end
        enable_i = 1'b0;
        tick();
        check_eq("t1_state",   128'(state_o), 128'(0));
        check_eq("t1_wrptr",   128'(wr_ptr_o), 128'(5));
        check_eq("t1_wrapped", 128'(wrapped_o), 128'(0));
        for (int i = 0; i < 5; i++) begin
            read_chk($sformatf("t1_rd%0d", i), AW'(i),
                     {(i == 4), 8'h01, 64'h10 + 64'(i)});
        end
        tick();
        check_eq("t1_idle_vld",  128'(rd_valid_o), 128'(0));
        check_eq("t1_hold_data", 128'(rd_data_o), 128'({1'b1, 8'h01, 64'h14}));

        // Wrapping capture with trigger and post count of 2.
        enable_i = 1'b1;
        tick();
        rd_en_i   = 1'b1;
        rd_addr_i = 4'd2;
        tick();
        rd_en_i   = 1'b0;
        check_eq("armed_rd_vld", 128'(rd_valid_o), 128'(1));
        check_eq("armed_rd_err", 128'(rd_err_o), 128'(1));
        check_eq("armed_rd_dat", 128'(rd_data_o), 128'(0));
        for (int k = 1; k <= 17; k++) begin
            beat(8'h02, 64'h100 + 64'(k), 1'b0);
        end
        check_eq("t2_wrptr17",  128'(wr_ptr_o), 128'(1));
        check_eq("t2_wrapped",  128'(wrapped_o), 128'(1));
        trig_i     = 1'b1;
        post_cnt_i = 4'd2;
        beat(8'h02, 64'h112, 1'b0);
        trig_i     = 1'b0;
        check_eq("t2_post",     128'(state_o), 128'(2));
        check_eq("t2_trigptr",  128'(trig_ptr_o), 128'(1));
        beat(8'h02, 64'h113, 1'b0);
        check_eq("t2_post19",   128'(state_o), 128'(2));
        beat(8'h02, 64'h114, 1'b1);
        tick();
        check_eq("t2_stopped",  128'(state_o), 128'(3));
        check_eq("t2_wrptr",    128'(wr_ptr_o), 128'(4));
        check_eq("t2_wrapped2", 128'(wrapped_o), 128'(1));
        beat(8'h02, 64'h999, 1'b0);
        check_eq("t2_stop_drop",  128'(drop_cnt_o), 128'(1));
        check_eq("t2_stop_wrptr", 128'(wr_ptr_o), 128'(4));
        tick();
        check_eq("t2_stays_stop", 128'(state_o), 128'(3));
        read_chk("t2_stop_rd0", 4'd0, {1'b0, 8'h02, 64'h111});
        enable_i = 1'b0;
        tick();
        check_eq("t2_idle", 128'(state_o), 128'(0));
        check_eq("t2_keep_trigptr", 128'(trig_ptr_o), 128'(1));
        read_chk("t2_rd1", 4'd1, {1'b0, 8'h02, 64'h112});
        read_chk("t2_rd3", 4'd3, {1'b1, 8'h02, 64'h114});

        // Zero post count with a beat in the trigger cycle.
        enable_i = 1'b1;
        tick();
        trig_i     = 1'b1;
        post_cnt_i = 4'd0;
        beat(8'h03, 64'hAA, 1'b0);
        trig_i     = 1'b0;
        check_eq("t3_post", 128'(state_o), 128'(2));
        tick();
        check_eq("t3_stopped", 128'(state_o), 128'(3));
        check_eq("t3_wrptr",   128'(wr_ptr_o), 128'(1));
        beat(8'h03, 64'hBB, 1'b0);
        beat(8'h03, 64'hCC, 1'b0);
        check_eq("t3_drop", 128'(drop_cnt_o), 128'(2));
        enable_i = 1'b0;
        tick();
        read_chk("t3_rd0", 4'd0, {1'b0, 8'h03, 64'hAA});

        // Reset pulse during POST.
        enable_i = 1'b1;
        tick();
        beat(8'h04, 64'h1, 1'b0);
        trig_i     = 1'b1;
        post_cnt_i = 4'd5;
        tick();
        trig_i     = 1'b0;
        check_eq("t4_post", 128'(state_o), 128'(2));
        rst_ni      = 1'b0;
        s_atvalid_i = 1'b1;
        #1;
        check_eq("t4_ready_rst", 128'(s_atready_o), 128'(0));
        tick();
        check_eq("t4_state", 128'(state_o), 128'(0));
        check_eq("t4_wrptr", 128'(wr_ptr_o), 128'(0));
        check_eq("t4_drop",  128'(drop_cnt_o), 128'(0));
        check_eq("t4_trig",  128'(trig_ptr_o), 128'(0));
        s_atvalid_i = 1'b0;
        rst_ni      = 1'b1;
        enable_i    = 1'b0;
        tick();

`ifdef ATB_TRACE_BUF_FILTER_EN
        // ATID filter: only 0x04..0x07 pass.
        flt_id_i   = 8'h04;
        flt_mask_i = 8'hFC;
        enable_i   = 1'b1;
        tick();
        beat(8'h05, 64'h55, 1'b0);
        beat(8'h09, 64'h99, 1'b0);
        check_eq("flt_wrptr", 128'(wr_ptr_o), 128'(1));
        check_eq("flt_drop",  128'(drop_cnt_o), 128'(1));
        enable_i = 1'b0;
        tick();
        read_chk("flt_rd0", 4'd0, {1'b0, 8'h05, 64'h55});
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
